// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: chain of skid-buffered valid/ready stages with flush and occupancy count
module pipe_reg_elastic #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int CW = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] m [DEPTH];
  logic [WIDTH-1:0] s [DEPTH];
  logic [WIDTH-1:0] din [DEPTH+1];
  logic [DEPTH-1:0] m_v, s_v, m_v_n, s_v_n, t_in, t_out;
  logic [DEPTH:0] vin, rdy;
  logic [CW-1:0] cnt_n;
  assign vin = {m_v, in_valid};
  assign rdy = {out_ready, ~s_v};
  assign out_valid = m_v[DEPTH-1];
  assign out_data = m[DEPTH-1];
  always_comb begin
    t_in = '0;
    t_out = '0;
    m_v_n = '0;
    s_v_n = '0;
    cnt_n = '0;
    din[0] = in_data;
    for (int k = 0; k < DEPTH; k++) begin
      din[k+1] = m[k];
      t_in[k] = vin[k] & rdy[k];
      t_out[k] = m_v[k] & rdy[k+1];
      m_v_n[k] = ~flush & (t_in[k] | s_v[k] | (m_v[k] & ~t_out[k]));
      s_v_n[k] = ~flush & (s_v[k] ? ~t_out[k] : (m_v[k] & t_in[k] & ~t_out[k]));
      cnt_n = cnt_n + CW'(m_v_n[k]) + CW'(s_v_n[k]);
    end
  end
  // in_ready gets its own flop so the upstream ready path starts at a register
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        m[k] <= RESET_VALUE;
        s[k] <= RESET_VALUE;
      end
      m_v <= '0;
      s_v <= '0;
      count <= '0;
      in_ready <= 1'b1;
    end else begin
      m_v <= m_v_n;
      s_v <= s_v_n;
      count <= cnt_n;
      in_ready <= ~s_v_n[0];
      for (int k = 0; k < DEPTH; k++)
        if (!flush) begin
          if (t_in[k] && (!m_v[k] || t_out[k])) m[k] <= din[k];
          else if (s_v[k] && t_out[k]) m[k] <= s[k];
          if (t_in[k] && m_v[k] && !t_out[k]) s[k] <= din[k];
        end
    end
endmodule
